truth_table_checker: RTL and testbench

Sequential sweep-and-compare stage for exhaustive checking of an N-input combinational function. It drives an incrementing argument vector into the function under test and samples the 1-bit result after a programmable settle time. Each result is compared against a reference truth table, and the checker accumulates a per-vector match mask and an error count. It reports pass/fail with a start/busy/done handshake. It replaces free-running bench sweeps with a reusable, synthesizable checker that sits around the combinational function block: the checker is upstream of the function on `args` and downstream of it on `f`.

---
 rtl/truth_table_checker.sv | 112 +++++++++++
 tb/tb_truth_table_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Sweeps args over every N_IN-bit vector, samples f after SETTLE extra cycles and scores it against REF.
// Latency: done pulses 2^N_IN*(SETTLE+1) edges after the start edge; no backpressure, abort cancels a sweep.
module truth_table_checker #(
    parameter int                  N_IN   = 5,
    parameter logic [2**N_IN-1:0]  REF    = 32'h114689AD,
    parameter int                  SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 f,
    output logic [N_IN-1:0]      args,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   match_mask,
    output logic [N_IN:0]        err_count
);

    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [3:0]           r_wait;
    logic [N_IN-1:0]      r_args;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [2**N_IN-1:0]   r_match_mask;
    logic [N_IN:0]        r_err_count;

    logic                 w_sample;
    logic                 w_last;
    logic                 w_miss;
    logic [N_IN:0]        w_err_next;

    assign w_sample   = (r_wait == SETTLE_W);
    assign w_last     = &r_args;
    // f may be X outside sample edges; w_miss is only consumed when w_sample is set
    assign w_miss     = f ^ REF[r_args];
    assign w_err_next = r_err_count + {{N_IN{1'b0}}, w_miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_args       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_match_mask <= '0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_args       <= '0;
                        r_wait       <= '0;
                        r_match_mask <= '0;
                        r_err_count  <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_args  <= '0;
                        r_wait  <= '0;
                        r_pass  <= 1'b0;
                    end else if (w_sample) begin
                        r_match_mask[r_args] <= ~w_miss;
                        r_err_count          <= w_err_next;
                        r_wait               <= '0;
                        if (w_last) begin
                            r_args  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                            r_state <= S_DONE;
                        end else begin
                            r_args <= r_args + 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign args       = r_args;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign match_mask = r_match_mask;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (default, all-match REF, SETTLE=2) scored against a table model.
module tb_truth_table_checker;

    localparam logic [31:0] REF_A = 32'h114689AD;
    localparam logic [31:0] REF_B = 32'h8FF88FF8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        start_drv = 1'b0;
    logic        abort_drv = 1'b0;
    logic        noise_en = 1'b0;
    logic        noise = 1'b0;
    logic [31:0] ftab_a = '0, ftab_b = '0, ftab_c = '0;

    logic        start_a, start_b, start_c, f_a, f_b, f_c;
    logic [4:0]  args_a, args_b, args_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [31:0] mask_a, mask_b, mask_c;
    logic [5:0]  err_a, err_b, err_c;

    assign start_a = start_drv && (sel == 0);
    assign start_b = start_drv && (sel == 1);
    assign start_c = start_drv && (sel == 2);
    assign f_a = ftab_a[args_a];
    assign f_b = ftab_b[args_b];
    assign f_c = noise_en ? noise : ftab_c[args_c];

    truth_table_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_drv), .f(f_a),
        .args(args_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .match_mask(mask_a), .err_count(err_a)
    );

    truth_table_checker #(.REF(REF_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .f(f_b),
        .args(args_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .match_mask(mask_b), .err_count(err_b)
    );

    truth_table_checker #(.SETTLE(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(1'b0), .f(f_c),
        .args(args_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .match_mask(mask_c), .err_count(err_c)
    );

    logic [4:0]  m_args;
    logic        m_busy, m_done, m_pass;
    logic [31:0] m_mask;
    logic [5:0]  m_err;

    always_comb begin
        m_args = args_a; m_busy = busy_a; m_done = done_a;
        m_pass = pass_a; m_mask = mask_a; m_err = err_a;
        case (sel)
            1: begin
                m_args = args_b; m_busy = busy_b; m_done = done_b;
                m_pass = pass_b; m_mask = mask_b; m_err = err_b;
            end
            2: begin
                m_args = args_c; m_busy = busy_c; m_done = done_c;
                m_pass = pass_c; m_mask = mask_c; m_err = err_c;
            end
            default: ;
        endcase
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] formula_tab();
        logic [31:0] t;
        logic [4:0]  a;
        t = '0;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            t[i] = (a[0] & a[1]) | (a[2] ^ a[3]);
        end
        return t;
    endfunction

    // Full sweep on the selected instance; called at #1 after a rising edge with the instance idle.
    task automatic do_sweep(input string tag, input int settle, input logic [31:0] ftab,
                            input logic [31:0] refv);
        logic [31:0] exp_mask;
        int          exp_err;
        int          n_busy, k;
        bit          seen;
        exp_mask = '0;
        exp_err  = 0;
        for (int i = 0; i < 32; i++) begin
            exp_mask[i] = (ftab[i] == refv[i]);
            if (ftab[i] != refv[i]) exp_err++;
        end
        case (sel)
            1:       ftab_b = ftab;
            2:       ftab_c = ftab;
            default: ftab_a = ftab;
        endcase
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        chk({tag, "_start_mask"}, m_mask, 0);
        chk({tag, "_start_err"},  m_err, 0);
        chk({tag, "_start_pass"}, m_pass, 0);
        n_busy = 0; k = 0; seen = 0;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            if (m_busy) begin
                chk({tag, "_args"}, m_args, k / (settle + 1));
                if (settle > 0) begin
                    noise_en = ((k % (settle + 1)) < settle);
                    noise    = 1'($urandom_range(0, 1));
                end
                n_busy++;
                k++;
            end else if (m_done) begin
                seen = 1;
            end
            if (!seen) begin
                @(posedge clk); #1;
            end
        end
        noise_en = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_cycles"}, n_busy, 32 * (settle + 1));
        chk({tag, "_mask"}, m_mask, exp_mask);
        chk({tag, "_err"},  m_err, exp_err);
        chk({tag, "_pass"}, m_pass, (exp_err == 0));
        chk({tag, "_args_wrap"}, m_args, 0);
        // a start during the DONE cycle must not launch another sweep
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        chk({tag, "_done_pulse"}, m_done, 0);
        @(posedge clk); #1;
        chk({tag, "_no_restart"}, m_busy, 0);
        chk({tag, "_hold_mask"}, m_mask, exp_mask);
        chk({tag, "_hold_err"},  m_err, exp_err);
        chk({tag, "_hold_pass"}, m_pass, (exp_err == 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ftf, rt, partial_mask;
        int          partial_err;
        ftf = formula_tab();

        #12;
        chk("rst_args", args_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_mask", mask_a, 0);
        chk("rst_err",  err_a, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        sel = 0;
        do_sweep("base", 0, ftf, REF_A);
        chk("base_mask_const", mask_a, 32'h6141F9AA);
        chk("base_err_const",  err_a, 17);

        sel = 1;
        do_sweep("allmatch", 0, ftf, REF_B);
        chk("allmatch_pass_const", pass_b, 1);

        sel = 0;
        do_sweep("fzero", 0, 32'h0, REF_A);
        chk("fzero_mask_const", mask_a, 32'hEEB97652);
        chk("fzero_err_const",  err_a, 13);

        sel = 2;
        do_sweep("settle", 2, ftf, REF_A);
        chk("settle_mask_const", mask_c, 32'h6141F9AA);
        chk("settle_err_const",  err_c, 17);

        for (int r = 0; r < 3; r++) begin
            rt = $urandom;
            sel = 0;
            do_sweep("rand_a", 0, rt, REF_A);
            sel = 2;
            do_sweep("rand_c", 2, rt, REF_A);
        end
        sel = 0;
        do_sweep("rand_pass", 0, REF_A ^ (32'h1 << $urandom_range(0, 31)), REF_A);
        do_sweep("exact_pass", 0, REF_A, REF_A);

        // abort on the 10th RUN cycle with start held high through RUN
        sel = 0;
        ftab_a = ftf;
        partial_mask = '0;
        partial_err  = 0;
        for (int i = 0; i < 9; i++) begin
            partial_mask[i] = (ftf[i] == REF_A[i]);
            if (ftf[i] != REF_A[i]) partial_err++;
        end
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("abort_run_args", args_a, i - 1);
            if (i < 10) begin
                start_drv = 1'b1;
            end else begin
                start_drv = 1'b0;
                abort_drv = 1'b1;
            end
        end
        @(posedge clk); #1;
        abort_drv = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_args", args_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_pass", pass_a, 0);
        chk("abort_err",  err_a, partial_err);
        chk("abort_mask", mask_a, partial_mask);
        @(posedge clk); #1;
        chk("abort_idle_done", done_a, 0);
        chk("abort_idle_busy", busy_a, 0);

        // async reset in RUN cycle 20
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_args", args_a, 19);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_args", args_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_done", done_a, 0);
        chk("arst_pass", pass_a, 0);
        chk("arst_mask", mask_a, 0);
        chk("arst_err",  err_a, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", done_a, 0);
        do_sweep("after_rst", 0, ftf, REF_A);
        chk("after_rst_mask_const", mask_a, 32'h6141F9AA);
        chk("after_rst_err_const",  err_a, 17);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
